// File: rtl/muldiv_iter_unit.sv
// rtl/muldiv_iter_unit.sv - EX-stage iterative multiply/divide unit owning HI/LO
module muldiv_iter_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]       r_state;
  logic             r_busy;
  logic             r_div_zero;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;

  logic             w_accept;
  logic             w_div_op;
  logic             w_div_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_mul_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc_in;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_dz_hi;

  assign w_accept     = i_start & ~r_busy & ~i_flush;
  assign w_div_op     = (i_op[2:1] == 2'b01);
  assign w_div_signed = (i_op == 3'b010);
  assign w_a_neg      = w_div_signed & i_src_a[WIDTH-1];
  assign w_b_neg      = w_div_signed & i_src_b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -i_src_a : i_src_a;
  assign w_b_mag      = w_b_neg ? -i_src_b : i_src_b;

  // Sign-extending both operands to 2*WIDTH makes the truncated product correct for signed ops.
  assign w_mul_signed = ~r_op[0];
  assign w_a_ext      = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext      = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod       = w_a_ext * w_b_ext;
  assign w_acc_in     = {r_hi, r_lo};
  assign w_mul_res    = !r_op[2] ? w_prod :
                        r_op[1]  ? (w_acc_in - w_prod) : (w_acc_in + w_prod);

  assign w_shift      = {r_rem, r_quo[WIDTH-1]};
  assign w_diff       = w_shift - {1'b0, r_b};
  assign w_fits       = ~w_diff[WIDTH];
  assign w_cnt_last   = (r_cnt == CW'(1));

  // r_a keeps the dividend magnitude so a divide-by-zero can return the original dividend.
  assign w_quo_fix    = r_q_neg ? -r_quo : r_quo;
  assign w_rem_fix    = r_r_neg ? -r_rem : r_rem;
  assign w_dz_hi      = r_r_neg ? -r_a : r_a;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (w_accept) begin
            r_busy <= 1'b1;
            r_op   <= i_op;
            if (w_div_op) begin
              r_state <= S_DIV;
              r_cnt   <= CW'(WIDTH);
              r_a     <= w_a_mag;
              r_b     <= w_b_mag;
              r_quo   <= w_a_mag;
              r_rem   <= '0;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_dz    <= (i_src_b == '0);
            end else begin
              r_state <= S_MUL;
              r_cnt   <= CW'(MUL_LAT);
              r_a     <= i_src_a;
              r_b     <= i_src_b;
            end
          end
        end
        S_MUL: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_cnt_last) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt - CW'(1);
            if (w_cnt_last) r_state <= S_FIX;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_div_zero <= r_dz;
            r_lo       <= r_dz ? '1 : w_quo_fix;
            r_hi       <= r_dz ? w_dz_hi : w_rem_fix;
          end
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_stall    = r_busy | i_start;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised multiply/divide unit for the EX stage. Owns the architectural HI/LO pair.
- Multiply has a configurable latency and adds signed/unsigned multiply-accumulate and multiply-subtract.
- Division is a true iterative restoring divider with defined divide-by-zero and overflow results.
- Supports flush (exception cancel) of an in-flight operation and gives the hazard unit a registered busy plus a combinational stall.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- MUL_LAT, 5, multiply busy cycles (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation this cycle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- flush  input  1  abort the in-flight operation (exception/IRQ)
- busy  output  1  registered; an operation is in flight
- stall  output  1  combinational: busy | start
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO
- div_zero  output  1  one-cycle pulse at commit of a divide with divisor 0

Behaviour:
- Reset (async): busy=0, hi=0, lo=0, div_zero=0, counter=0, internal datapath regs=0. Reset mid-operation discards the operation.
- Accept: on a clk edge with start=1, busy=0, flush=0.
  - Operands are latched and busy goes to 1 at that edge (E0).
  - start while busy=1 is ignored; the hazard unit must hold it.
- States: IDLE, MUL, DIV, FIX.
  - IDLE->MUL for op 000/001/1xx. IDLE->DIV for 010/011.
- MUL:
  - Product is formed from the latched operands: signed for 000/100/110, unsigned otherwise, 2*WIDTH bits.
  - Down-counter loaded with MUL_LAT at E0. Commit on edge E_MUL_LAT, where busy->0 and the state returns to IDLE.
  - MULT/MULTU commit {hi,lo}=product.
  - MADD/MADDU commit {hi,lo}={hi,lo}+product. MSUB/MSUBU commit {hi,lo}={hi,lo}-product.
  - Accumulate arithmetic is modulo 2^(2*WIDTH) and uses HI/LO as they are at the commit edge.
- DIV:
  - At E0, latch the magnitudes of the operands (signed ops) and the result signs.
  - Edges E1..E_WIDTH each perform one restoring shift/subtract step, MSB first.
  - Edge E_WIDTH+1 (state FIX) applies the sign fix and commits lo=quotient, hi=remainder; busy->0.
  - Total busy = WIDTH+1 cycles.
  - Signed results: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (src_b=0), signed or unsigned: commits lo=all ones, hi=src_a. div_zero=1 for exactly the cycle after commit. Latency is unchanged.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo=-2^(WIDTH-1), hi=0, div_zero=0.
- MTHI/MTLO:
  - If busy=0, hi_we/lo_we write wdata at the edge.
  - If busy=1, the writes are ignored.
  - Same-cycle start with hi_we/lo_we: both take effect, and an accumulate op later uses the written value.
- Flush:
  - flush=1 with busy=1: the operation is aborted at that edge. busy->0, state->IDLE, hi/lo unchanged, no div_zero pulse.
  - flush=1 with start=1 and busy=0: the operation is not accepted.
  - flush does not block hi_we/lo_we when busy=0.
- Outputs hi/lo are the registers driven directly. During busy they show the pre-operation values; consumers stall on busy.
- Back-to-back: a new start is accepted in the cycle after the commit edge (busy=0). There is no same-edge restart.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU 100/7 -> busy high 33 cycles; then lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV src_a=0x12, src_b=0 -> lo=0xFFFFFFFF, hi=0x12, div_zero pulse 1 cycle. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, no pulse.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Then MSUB 1*2 -> hi=0, lo=0xFFFFFFFE.
- DIV started, flush asserted on the 10th busy cycle -> busy=0 next cycle, hi/lo keep their prior values. MTHI while busy -> hi unchanged.
- Reset asserted asynchronously mid-MULT -> busy, hi, lo read 0 immediately. start held during busy -> accepted only after busy falls; stall=1 throughout.
